// File: rtl/digit_entry_pkg.sv
// Purpose: shared types and constants for the push-button digit entry path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package digit_entry_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] bcd_t;

    // Bit positions of each function inside the 4-bit KEY bus.
    localparam int KEY_INC  = 0;
    localparam int KEY_CUR  = 1;
    localparam int KEY_LOAD = 2;
    localparam int KEY_CLR  = 3;

    typedef enum logic [1:0] {
        UP,
        CNT_DN,
        DOWN,
        CNT_UP
    } deb_state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_INC,
        ACT_CUR,
        ACT_LOAD,
        ACT_CLR
    } action_t;

    // Resolves simultaneous press events; only the most important one acts.
    function automatic action_t pick_action(input logic [3:0] ev);
        action_t a;
        if (ev[KEY_CLR])       a = ACT_CLR;
        else if (ev[KEY_LOAD]) a = ACT_LOAD;
        else if (ev[KEY_CUR])  a = ACT_CUR;
        else if (ev[KEY_INC])  a = ACT_INC;
        else                   a = ACT_NONE;
        return a;
    endfunction

    // Single-digit decimal increment; wraps 9 -> 0 and never carries.
    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Purpose: 2-flop synchronizer + debounce FSM for one active-low push-button.
// Latency: press_evt fires DEBOUNCE_CYCLES+3 edges after the key is first sampled low.
// Backpressure: none; press_evt is a 1-cycle pulse that must be consumed immediately.
//
// Ports: clock, reset_L (async active-low), key_n (raw active-low key),
//        press_evt (one registered pulse per accepted press, no auto-repeat).
module key_debouncer
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_L,
    input  logic key_n,
    output logic press_evt
);

    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Synchronizer flops reset to the released level so a key held through
    // reset is seen as a fresh press once reset lifts.
    logic          key_meta_q, key_meta_d;
    logic          key_sync_q, key_sync_d;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          pressed;

    assign pressed = ~key_sync_q;

    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        press_d    = 1'b0;
        case (state_q)
            UP: begin
                if (pressed) begin
                    state_d = CNT_DN;
                    cnt_d   = CNT_ONE;
                end
            end
            CNT_DN: begin
                if (!pressed) begin
                    state_d = UP;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_d = CNT_UP;
                    cnt_d   = CNT_ONE;
                end
            end
            CNT_UP: begin
                // A bounce back to pressed returns to DOWN without a new event.
                if (pressed) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = UP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = UP;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            state_q    <= UP;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press_evt = press_q;

endmodule

// File: rtl/digit_entry.sv
// Purpose: push-button editor for an 8-digit BCD value with a blinking cursor.
// Latency: digit update visible DEBOUNCE_CYCLES+4 edges after KEY is first sampled low.
// Backpressure: none; every accepted press acts on the following edge.
//
// Ports: clock, reset_L (async active-low), KEY[3:0] raw active-low buttons
//        (0=inc, 1=cursor right, 2=load, 3=clear), SW[3:0] load value;
//        bcd[31:0] digits (digit 0 rightmost), turn_on[7:0] per-digit enable,
//        cursor[2:0] selected digit, err one-cycle pulse on rejected load.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [3:0]              KEY,
    input  logic [3:0]              SW,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   turn_on,
    output logic [2:0]              cursor,
    output logic                    err
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [3:0] press_evt;
    action_t    action;
    bcd_t       cur_dig;

    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]              cursor_q, cursor_d;
    logic                    err_q, err_d;
    logic [NUM_DIGITS-1:0]   turn_on_q, turn_on_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock    (clock),
            .reset_L  (reset_L),
            .key_n    (KEY[k]),
            .press_evt(press_evt[k])
        );
    end

    assign action  = pick_action(press_evt);
    assign cur_dig = bcd_q[{cursor_q, 2'b00} +: 4];

    always_comb begin
        bcd_d    = bcd_q;
        cursor_d = cursor_q;
        err_d    = 1'b0;
        case (action)
            ACT_CLR:  bcd_d = '0;
            ACT_LOAD: begin
                if (SW <= 4'd9) bcd_d[{cursor_q, 2'b00} +: 4] = SW;
                else            err_d = 1'b1;
            end
            ACT_CUR:  cursor_d = cursor_q + 3'd1;   // 7 -> 0 by natural wrap
            ACT_INC:  bcd_d[{cursor_q, 2'b00} +: 4] = bcd_inc(cur_dig);
            default:  ;
        endcase
    end

    // Free-running blink timebase, independent of cursor moves.
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
        end
    end

    // Built from next-state cursor/phase so the registered enable lines up
    // with the registered cursor in the same cycle.
    always_comb begin
        turn_on_d           = '1;
        turn_on_d[cursor_d] = phase_d;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            bcd_q       <= '0;
            cursor_q    <= '0;
            err_q       <= 1'b0;
            turn_on_q   <= '1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            bcd_q       <= bcd_d;
            cursor_q    <= cursor_d;
            err_q       <= err_d;
            turn_on_q   <= turn_on_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign bcd     = bcd_q;
    assign cursor  = cursor_q;
    assign err     = err_q;
    assign turn_on = turn_on_q;

endmodule
